// File: rtl/split8_rr_arb_if.sv
// Handshake bundle between the 8-way round-robin arbiter and its requesters/splitter.
interface split8_rr_arb_if #(
  parameter int N = 8
);
  logic         enable;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout;

  modport master (
    output enable, req,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  enable, req,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/split8_rr_arb.sv
// 8-way round-robin arbiter; registered one-hot grant, one dead cycle between owners (1-cycle grant latency).
// Optional hold-time limit under SPLIT8_ARB_HOLD_LIMIT_EN; owners are never preempted otherwise.
module split8_rr_arb #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst_n,
  split8_rr_arb_if.slave bus
);

  if (N != 8 || HOLD_MAX < 2 || HOLD_MAX > 65535 || CNT_W < 1 || CNT_W > 32 ||
      (64'(1) << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
    $error("split8_rr_arb: unsupported N/HOLD_MAX/CNT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] idx;
  logic       any_req;

`ifdef SPLIT8_ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt;
`endif

  // Descending scan so the lane closest to ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (bus.req[idx]) win = idx;
    end
  end

  assign any_req = |bus.req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
`ifdef SPLIT8_ARB_HOLD_LIMIT_EN
      cnt          <= '0;
`endif
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (bus.enable && any_req) begin
            bus.grant    <= N'(1) << win;
            bus.grant_id <= win;
            bus.busy     <= 1'b1;
            state        <= GRANT;
`ifdef SPLIT8_ARB_HOLD_LIMIT_EN
            cnt          <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // Release moves the owner to lowest priority for the next arbitration.
          if (!bus.req[bus.grant_id]) begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            ptr       <= bus.grant_id + 3'd1;
            state     <= GAP;
          end
`ifdef SPLIT8_ARB_HOLD_LIMIT_EN
          else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
            bus.grant   <= '0;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b1;
            ptr         <= bus.grant_id + 3'd1;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split8_rr_arb.sv
// Directed + randomized bench for split8_rr_arb against an owner/pointer reference model.
module tb_split8_rr_arb;

  localparam int HOLD_MAX = 16;
`ifdef SPLIT8_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  split8_rr_arb_if #(.N(8)) bus ();

  split8_rr_arb #(.N(8), .HOLD_MAX(HOLD_MAX), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int ntests = 0;
  int nfail  = 0;

  // Reference model: who owns the resource, who had it last, and where the search starts.
  int m_owner;
  int m_ptr;
  int m_last;
  int m_held;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ntests++;
    assert (obs === exp_v)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  // Idle and gap behave identically from the outside: both arbitrate the cycle after a release.
  function automatic void model_step(input bit en, input logic [7:0] r);
    bit found;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (HOLD_EN && m_held == HOLD_MAX) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else if (en && r != 8'h00) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          found   = 1'b1;
        end
      end
      m_last = m_owner;
      m_held = 1;
    end
  endfunction

  task automatic tick();
    model_step(bus.enable, bus.req);
    @(posedge clk);
    #1;
    check("grant",    32'(bus.grant),    (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("grant_id", 32'(bus.grant_id), 32'(m_last));
    check("busy",     32'(bus.busy),     32'(m_owner >= 0));
    check("timeout",  32'(bus.timeout),  32'(m_to));
  endtask

  initial begin
    int w;
    logic [7:0] r;

    // Reset state
    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.req    = 8'h00;
    model_reset();
    #12;
    check("rst_grant",    32'(bus.grant),    32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_timeout",  32'(bus.timeout),  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Single requester: one-cycle latency, release clears grant
    bus.req = 8'h04;
    tick();
    check("lane2_grant", 32'(bus.grant),    32'h04);
    check("lane2_id",    32'(bus.grant_id), 32'd2);
    for (int i = 0; i < 9; i++) tick();
    bus.req = 8'h00;
    tick();
    check("lane2_release", 32'(bus.grant), 32'h00);

    // ptr=3 with lanes 0 and 2 requesting wraps past 7 to lane 0
    bus.req = 8'h05;
    tick();
    check("wrap_lane0", 32'(bus.grant), 32'h01);
    bus.req = 8'h04;
    tick();
    bus.req = 8'h05;
    tick();
    check("after_lane0_lane2", 32'(bus.grant), 32'h04);

    // Asynchronous reset mid-ownership
    rst_n = 1'b0;
    #2;
    check("async_rst_grant", 32'(bus.grant), 32'h00);
    check("async_rst_busy",  32'(bus.busy),  32'd0);
    model_reset();
    bus.req = 8'hFF;
    rst_n   = 1'b1;

    // All lanes requesting: strict rotation 0..7,0 with exactly one dead cycle
    for (int n = 0; n < 9; n++) begin
      w = 0;
      while (bus.grant == 8'h00 && w < 4) begin
        tick();
        w++;
      end
      r = 8'h01 << (n % 8);
      check("rot_order", 32'(bus.grant), 32'(r));
      check("rot_gap",   32'(w),         32'd1);
      tick();
      tick();
      bus.req = 8'hFF & ~bus.grant;
      tick();
      bus.req = 8'hFF;
    end
    bus.req = 8'h00;
    tick();
    tick();

    // enable gates new grants only
    bus.enable = 1'b0;
    bus.req    = 8'h10;
    for (int i = 0; i < 3; i++) tick();
    check("en_off_nogrant", 32'(bus.grant), 32'h00);
    bus.enable = 1'b1;
    tick();
    check("en_on_grant", 32'(bus.grant), 32'h10);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("en_off_retain", 32'(bus.grant), 32'h10);
    bus.req = 8'h00;
    tick();
    tick();
    bus.enable = 1'b1;

    // Hold limit: lane 0 then lane 1 held continuously
    bus.req = 8'h03;
    for (int i = 0; i < HOLD_MAX; i++) tick();
    check("hold_lane0_last", 32'(bus.grant), 32'h01);
    tick();
`ifdef SPLIT8_ARB_HOLD_LIMIT_EN
    check("hold_forced_off", 32'(bus.grant),   32'h00);
    check("hold_timeout",    32'(bus.timeout), 32'd1);
    tick();
    check("hold_lane1", 32'(bus.grant), 32'h02);
`else
    check("hold_unbounded", 32'(bus.grant),   32'h01);
    check("hold_no_to",     32'(bus.timeout), 32'd0);
`endif
    bus.req = 8'h00;
    tick();
    tick();

    // Randomized traffic; owners usually keep requesting, occasionally for a long time
    for (int i = 0; i < 600; i++) begin
      r = 8'($urandom);
      if (m_owner >= 0 && ($urandom % 16) != 0) r[m_owner] = 1'b1;
      bus.req    = r;
      bus.enable = ($urandom % 8) != 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
